// File: rtl/fiber_block_streamer.sv
// Block-write stream transmitter: reads length-prefixed blocks from memory and emits
// header, data and a done token. Optional stall counter under FIBER_BLOCK_STREAMER_PERF_EN.
module fiber_block_streamer #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_num_blocks,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W:0]   blk_out,
  output logic              blk_out_valid,
  input  logic              blk_out_ready,
  output logic              busy,
  output logic              done
`ifdef FIBER_BLOCK_STREAMER_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_W:0] DoneTok = {1'b1, DATA_W'(16'h0100)};

  typedef enum logic [2:0] {
    StIdle, StHdrRd, StHdrWait, StBody, StDoneTok, StDrain, StFinish
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         blocks_q;
  logic [DATA_W-1:0]   words_q;
  logic                ren_q;
  logic                hold_v_q;
  logic [DATA_W-1:0]   hold_q;
  logic [DATA_W:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;

  logic                pop, inflight, credit, rd_push, tok_push, push, start_ok;
  logic [CntW:0]       occ_eff;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W:0]     push_word;

  assign blk_out_valid = (count_q != '0);
  assign blk_out       = fifo_q[rd_ptr_q];
  assign pop           = clk_en & blk_out_valid & blk_out_ready;

  // A read is in flight either on the memory bus or parked in hold_q while clk_en was low.
  assign inflight = ren_q | hold_v_q;
  assign occ_eff  = {1'b0, count_q} + {{CntW{1'b0}}, inflight} - {{CntW{1'b0}}, pop};
  assign credit   = occ_eff < (CntW + 1)'(FIFO_DEPTH);

  assign mem_ren  = clk_en & credit & ((state_q == StHdrRd) | (state_q == StBody));
  assign mem_addr = addr_q;

  assign rd_data   = hold_v_q ? hold_q : mem_rdata;
  assign rd_push   = clk_en & inflight;
  assign tok_push  = clk_en & (state_q == StDoneTok) & ~inflight & credit;
  assign push      = rd_push | tok_push;
  assign push_word = rd_push ? {1'b0, rd_data} : DoneTok;

  assign start_ok = clk_en & start & ((state_q == StIdle) | (state_q == StFinish));
  assign busy     = (state_q != StIdle) & (state_q != StFinish);
  assign done     = (state_q == StFinish);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      blocks_q <= '0;
      words_q  <= '0;
      ren_q    <= 1'b0;
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else if (flush) begin
      state_q  <= StIdle;
      ren_q    <= 1'b0;
      hold_v_q <= 1'b0;
    end else begin
      ren_q <= mem_ren;
      if (clk_en) begin
        hold_v_q <= 1'b0;
      end else if (ren_q) begin
        hold_v_q <= 1'b1;
        hold_q   <= mem_rdata;
      end
      if (clk_en) begin
        if (mem_ren) addr_q <= addr_q + 1'b1;
        unique case (state_q)
          StIdle, StFinish: begin
            if (start) begin
              addr_q   <= cfg_base_addr;
              blocks_q <= cfg_num_blocks;
              state_q  <= (cfg_num_blocks == 16'd0) ? StDoneTok : StHdrRd;
            end
          end
          StHdrRd: if (mem_ren) state_q <= StHdrWait;
          StHdrWait: begin
            if (rd_push) begin
              if (rd_data == '0) begin
                blocks_q <= blocks_q - 16'd1;
                state_q  <= (blocks_q > 16'd1) ? StHdrRd : StDoneTok;
              end else begin
                words_q <= rd_data;
                state_q <= StBody;
              end
            end
          end
          StBody: begin
            if (mem_ren) begin
              words_q <= words_q - 1'b1;
              if (words_q == DATA_W'(1)) begin
                blocks_q <= blocks_q - 16'd1;
                state_q  <= (blocks_q > 16'd1) ? StHdrRd : StDoneTok;
              end
            end
          end
          StDoneTok: if (tok_push) state_q <= StDrain;
          StDrain:   if (!blk_out_valid) state_q <= StFinish;
          default:   state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clk_en) begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_word;
        wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

`ifdef FIBER_BLOCK_STREAMER_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (flush || start_ok) begin
      stall_q <= '0;
    end else if (clk_en && blk_out_valid && !blk_out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fiber_block_streamer.sv
// Self-checking bench for fiber_block_streamer: memory model, expected-word scoreboard,
// latency/throughput, wrap, flush and optional stall-counter checks.
`timescale 1ns/1ps
module tb_fiber_block_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  cfg_base_addr = '0;
  logic [15:0] cfg_num_blocks = '0;
  logic [8:0]  mem_addr;
  logic        mem_ren;
  logic [15:0] mem_rdata = '0;
  logic [16:0] blk_out;
  logic        blk_out_valid;
  logic        blk_out_ready = 1'b1;
  logic        busy, done;
`ifdef FIBER_BLOCK_STREAMER_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] mem_model [512];
  logic [16:0] exp_q [$];
  logic [8:0]  addr_log [$];
  int cyc = 0, t0 = 0, first_acc = -1, last_acc = -1;
  int n_reads = 0, n_acc = 0, n_tok = 0, max_q = 0;
  logic rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [16:0] prev_word = '0;

  fiber_block_streamer #(.ADDR_W(9), .DATA_W(16), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .flush          (flush),
    .start          (start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_blocks (cfg_num_blocks),
    .mem_addr       (mem_addr),
    .mem_ren        (mem_ren),
    .mem_rdata      (mem_rdata),
    .blk_out        (blk_out),
    .blk_out_valid  (blk_out_valid),
    .blk_out_ready  (blk_out_ready),
    .busy           (busy),
    .done           (done)
`ifdef FIBER_BLOCK_STREAMER_PERF_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ren) mem_rdata <= mem_model[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) blk_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard and stream-protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (mem_ren) begin
        n_reads++;
        addr_log.push_back(mem_addr);
      end
      if (prev_stall) begin
        check("hold_valid", 32'(blk_out_valid), 32'd1);
        check("hold_data", 32'(blk_out), 32'(prev_word));
      end
      if (blk_out_valid && blk_out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("word", 32'(blk_out), 32'(exp_q.pop_front()));
        n_acc++;
        if (blk_out[16]) n_tok++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (n_reads - (n_acc - n_tok) > max_q) max_q = n_reads - (n_acc - n_tok);
      prev_stall = blk_out_valid && !blk_out_ready;
      prev_word  = blk_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic build_exp(input logic [8:0] base, input int nblk);
    logic [8:0]  a;
    logic [15:0] len;
    a = base;
    for (int b = 0; b < nblk; b++) begin
      len = mem_model[a];
      exp_q.push_back({1'b0, len});
      a++;
      for (int i = 0; i < int'(len); i++) begin
        exp_q.push_back({1'b0, mem_model[a]});
        a++;
      end
    end
    exp_q.push_back(17'h10100);
  endtask

  // Called at #1 after an edge; returns in cycle 1 (just after the sampling edge E0).
  task automatic start_run(input logic [8:0] base, input logic [15:0] n);
    cfg_base_addr  = base;
    cfg_num_blocks = n;
    exp_q.delete();
    addr_log.delete();
    build_exp(base, int'(n));
    n_reads = 0; n_acc = 0; n_tok = 0; max_q = 0; first_acc = -1; last_acc = -1;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k;
    k = 0;
    while (!(done && exp_q.size() == 0) && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [8:0] exp_addr [3];
    int found;
    for (int i = 0; i < 512; i++) mem_model[i] = 16'(i * 37 + 5);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ren", 32'(mem_ren), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_out", 32'(blk_out), 32'd0);
    check("rst_valid", 32'(blk_out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single block of three words from base 0: latency and single-bubble throughput.
    mem_model[0] = 16'd3; mem_model[1] = 16'h000A; mem_model[2] = 16'h000B;
    mem_model[3] = 16'h000C;
    start_run(9'd0, 16'd1);
    check("c1_ren", 32'(mem_ren), 32'd1);
    check("c1_addr", 32'(mem_addr), 32'd0);
    check("c1_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("c2_valid", 32'(blk_out_valid), 32'd0);
    @(posedge clk); #1;
    check("c3_valid", 32'(blk_out_valid), 32'd1);
    wait_done("t1", 100);
    check("t1_first", 32'(first_acc - t0), 32'd2);
    check("t1_span", 32'(last_acc - first_acc), 32'd5);

    // Zero-length first block, started from FINISH.
    mem_model[20] = 16'd0; mem_model[21] = 16'd2; mem_model[22] = 16'h0005;
    mem_model[23] = 16'h0006;
    start_run(9'd20, 16'd2);
    check("t2_done_low", 32'(done), 32'd0);
    wait_done("t2", 100);

    // Four blocks of seven words under random ready.
    for (int b = 0; b < 4; b++) begin
      mem_model[100 + 8 * b] = 16'd7;
      for (int i = 1; i < 8; i++) mem_model[100 + 8 * b + i] = 16'(16'hA000 + 16 * b + i);
    end
    rand_ready = 1'b1;
    start_run(9'd100, 16'd4);
    wait_done("t3", 2000);
    rand_ready = 1'b0;
    @(posedge clk); #1;
    blk_out_ready = 1'b1;
    check("t3_occ_le2", 32'(max_q <= 2), 32'd1);
    check("t3_reads", 32'(n_reads), 32'd32);

    // Zero blocks: done token only, no memory reads.
    start_run(9'd50, 16'd0);
    wait_done("t4", 100);
    check("t4_reads", 32'(n_reads), 32'd0);

    // Address wrap at the top of memory.
    mem_model[510] = 16'd2; mem_model[511] = 16'h1111; mem_model[0] = 16'h2222;
    exp_addr[0] = 9'd510; exp_addr[1] = 9'd511; exp_addr[2] = 9'd0;
    start_run(9'd510, 16'd1);
    wait_done("t5", 100);
    check("t5_nreads", 32'(addr_log.size()), 32'd3);
    for (int i = 0; i < addr_log.size() && i < 3; i++)
      check("t5_addr", 32'(addr_log[i]), 32'(exp_addr[i]));

    // Flush in the middle of a body with a read in flight, then a clean restart.
    start_run(9'd100, 16'd4);
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(posedge clk); #1;
      if (mem_ren && n_acc >= 3 && n_acc < 6) found = 1;
    end
    check("t6_found", 32'(found), 32'd1);
    flush = 1'b1;
    blk_out_ready = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    blk_out_ready = 1'b1;
    check("t6_valid", 32'(blk_out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ren", 32'(mem_ren), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    start_run(9'd100, 16'd4);
    wait_done("t6", 200);

`ifdef FIBER_BLOCK_STREAMER_PERF_EN
    mem_model[0] = 16'd3;
    blk_out_ready = 1'b0;
    start_run(9'd0, 16'd1);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (blk_out_valid) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("t7_valid", 32'(found), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    blk_out_ready = 1'b1;
    wait_done("t7", 100);
    check("t7_stall", stall_cycles, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fiber_block_streamer.md
# fiber_block_streamer

Transmitter for the sparse-tile block-write protocol. It reads a packed sequence of blocks from a single-port memory and emits them as a 17-bit ready/valid stream: one length header per block, then that block's data words, then the done token 17'h10100. It sits on the GLB/tile side and drives a write scanner's `block_wr_in` port. It is the synthesizable counterpart to the behavioural `glb_write` driver used in unit benches.

## Interface
Parameters:
- `ADDR_W`, 9: memory address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 16: memory word and payload width. Stream width is DATA_W+1.
- `FIFO_DEPTH`, 2: output buffer depth. Must be ≥2 for full throughput.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  when low, all state holds and `mem_ren`=0.
- `flush`  in  1  synchronous clear to IDLE; FIFO emptied.
- `start`  in  1  single-cycle pulse; accepted only in IDLE or FINISH.
- `cfg_base_addr`  in  ADDR_W  address of the first header; sampled on `start`.
- `cfg_num_blocks`  in  16  number of blocks; sampled on `start`.
- `mem_addr`  out  ADDR_W  read address.
- `mem_ren`  out  1  read enable.
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `mem_ren`.
- `blk_out`  out  DATA_W+1  stream word. Bit 16 is the control flag.
- `blk_out_valid`  out  1  stream valid.
- `blk_out_ready`  in  1  stream ready.
- `busy`  out  1  high in all states except IDLE and FINISH.
- `done`  out  1  level; high in FINISH.

## Operation
- Memory layout from `cfg_base_addr`: for each block, `len`, `w0`…`w(len-1)`. Consecutive blocks are contiguous.
- Output per block:
  - header `{1'b0, len}`;
  - then `{1'b0, wi}` for each data word;
  - after the last block, `{1'b1, 16'h0100}`.
- FSM states:
  - **IDLE**: on `start`, go to HDR_RD. If `cfg_num_blocks`=0, go to DONE_TOK instead.
  - **HDR_RD**: issue the header read when credit is available, then go to HDR_WAIT.
  - **HDR_WAIT**: capture `len` from `mem_rdata` and push the header into the FIFO.
    - `len`=0: decrement the block count. Go to HDR_RD if blocks remain, else DONE_TOK.
    - otherwise: go to BODY.
  - **BODY**: issue one read per cycle while credit is available. After the `len`-th read, go to HDR_RD if blocks remain, else DONE_TOK.
  - **DONE_TOK**: push the done token once the FIFO has room, then go to DRAIN.
  - **DRAIN**: wait for the FIFO to empty, then go to FINISH.
  - **FINISH**: `done`=1. A new `start` behaves as in IDLE.
- Credit rule: issue a read only if (FIFO occupancy + reads in flight) < FIFO_DEPTH. The FIFO must never overflow. Every read's data is pushed the cycle it returns.
- `mem_addr` increments by 1 per issued read. It is wide enough to wrap from 2^ADDR_W−1 to 0.
- Data words go out unmodified. Memory contents never set bit 16.
- `start` outside IDLE/FINISH is ignored.

## Timing
- Reset values:
  - `mem_addr`=0, `mem_ren`=0
  - `blk_out`=0, `blk_out_valid`=0
  - `busy`=0, `done`=0
  - FSM in IDLE, FIFO empty.
- Start-to-first-valid latency, with `start` sampled at edge E0:
  - `mem_ren`=1 in cycle 1;
  - header pushed at E2;
  - `blk_out_valid`=1 in cycle 3.
- Throughput:
  - one word per cycle within a block under continuous ready;
  - one bubble per block between the header return and the first body read.
- `blk_out`/`blk_out_valid` come from the FIFO head, registered. Once valid is asserted, it and the data stay stable until accepted. A transfer occurs when `blk_out_valid & blk_out_ready`.
- Simultaneous push and pop on a full FIFO is legal. Occupancy is unchanged.
- `flush` or `rst_n` mid-operation: the next cycle has `blk_out_valid`=0, `mem_ren`=0, and `busy`=0. Returning read data from a read in flight is discarded.
- `done` goes low in the cycle after an accepted `start`.

## Configuration
- Macro `FIBER_BLOCK_STREAMER_PERF_EN`.
- Defined: adds output `stall_cycles` (32 bits).
  - Increments each `clk_en` cycle with `blk_out_valid & ~blk_out_ready`.
  - Saturates at 2^32−1.
  - Cleared by reset, `flush`, or an accepted `start`.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Base 0, 1 block, mem[0..3]=3,0xA,0xB,0xC, ready=1 → 0x00003,0x0000A,0x0000B,0x0000C,0x10100 on consecutive accepts except one header bubble. First valid in cycle 3. `done`=1 after drain.
- Two blocks, mem=0,2,0x5,0x6 (zero-length first) → 0x00000,0x00002,0x00005,0x00006,0x10100.
- Random `blk_out_ready` (50%), 4 blocks of length 7 → exact word sequence with no loss or duplication. FIFO never exceeds 2; reads in flight + occupancy ≤ 2 every cycle.
- `cfg_num_blocks`=0 → only 0x10100; `mem_ren` never asserted.
- Base 510, 1 block, len 2 → reads at 510,511,0; output 0x00002,mem[511],mem[0],0x10100.
- `flush` during BODY with a read in flight → next cycle valid=0 and busy=0, no stale word emitted. A following `start` reproduces the full correct stream. With `FIBER_BLOCK_STREAMER_PERF_EN`, ready held low for 5 cycles while valid → `stall_cycles`=5.
